regs_dump_reader: RTL
=====================

// Module: regs_dump_reader
// PURPOSE
//  Sequential reader for the 32x32 register file: on a start pulse it walks a register
//  address range through one read port and streams each value out with a valid/ready handshake.
//  It sits between the core's register file read port and the debug/trace unit.
//  It also monitors the register file write port and flags a dump as stale when a dumped
//  register is overwritten before the dump completes.
// PARAMETERS
//  ADDR_W   5   register address width; the register file has 2**ADDR_W entries.
//  DATA_W   32  register data width.
//  SKIP_R0  1   1: address 0 is stepped over and never emitted. 0: address 0 is emitted as 0.
// PORTS
//  clk         in   1       core clock; all state updates on posedge.
//  rst         in   1       reset; asynchronous, active-high.
//  start       in   1       1-cycle request to begin a dump; ignored while busy=1.
//  first_addr  in   ADDR_W  first address of the range; sampled on an accepted start.
//  last_addr   in   ADDR_W  last address of the range, inclusive; sampled on an accepted start.
//  rf_addr     out  ADDR_W  drives the register file read-address port.
//  rf_rdata    in   DATA_W  combinational read data returned for rf_addr.
//  wt_addr     in   ADDR_W  register file write address (monitor only).
//  wt_en       in   1       register file write enable (monitor only).
//  out_valid   out  1       out_data/out_addr/out_last hold a beat.
//  out_ready   in   1       consumer accepts the beat when out_valid & out_ready.
//  out_data    out  DATA_W  register value.
//  out_addr    out  ADDR_W  register address of the beat.
//  out_last    out  1       final beat of the dump.
//  busy        out  1       a dump is in progress, from the accepted start until done.
//  done        out  1       1-cycle pulse after the final beat is accepted.
//  stale       out  1       valid while done=1: a dumped register was written during the dump.
// BEHAVIOUR
//  Reset: all outputs are 0 (rf_addr=0). FSM=IDLE, emitted mask cleared.
//   Reset mid-dump aborts the dump immediately and emits no done.
//  FSM states: IDLE, RUN, DRAIN, FIN.
//   IDLE: if start, latch the range, set cnt = ((last-first) mod 2**ADDR_W)+1, set addr=first,
//    clear the mask and the stale flag, then go to RUN.
//   RUN: rf_addr=addr. Capture occurs when (!out_valid | out_ready):
//    - the output register loads rf_rdata and addr, and sets its mask bit;
//    - addr increments mod 2**ADDR_W (31 wraps to 0); cnt decrements;
//    - out_last=1 when cnt==1.
//    With SKIP_R0=1 and addr==0: no capture; addr increments and cnt decrements.
//    When cnt reaches 0, go to DRAIN.
//   DRAIN: hold until the pending beat is accepted, or until no beat is pending. Then go to FIN.
//   FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
//  Latency: start at edge k gives the first out_valid after edge k+1.
//   With out_ready held at 1, one beat is emitted per cycle.
//  Handshake: while out_valid=1 and out_ready=0, out_* stay stable. out_valid never drops
//   without acceptance.
//  Range: first>last wraps through 31->0. first==last gives one beat.
//   A range of only address 0 with SKIP_R0=1 emits zero beats; done still pulses and
//   out_last is never asserted.
//  Stale: sticky flag. It is set when wt_en=1, wt_addr!=0 and mask[wt_addr]=1 at a posedge,
//   including an address captured at that same edge. The write lands on negedge, after the
//   capture. The flag is cleared on an accepted start.
//  The register file writes on negedge, so a value sampled at posedge includes every write
//   issued in earlier cycles.
//  A start asserted while busy=1 has no effect. A start asserted in the FIN cycle is ignored.
// STRUCTURE
//  Shared package: state encoding (IDLE/RUN/DRAIN/FIN) and the ADDR_W/DATA_W defaults.
//  Sub-module regs_dump_outreg: 1-entry valid/ready output register (data, addr, last).
//  The FSM, counters and emitted mask live in the top level.
// TESTING
//  1. Preload r1..r31=i*16. start, first=1, last=4, out_ready=1.
//     -> 4 beats on consecutive cycles: (1,0x10)..(4,0x40); out_last on addr 4; done, stale=0.
//  2. first=30, last=2, SKIP_R0=1.
//     -> beats at addresses 30,31,1,2 in that order; address 0 is skipped; out_last on 2.
//  3. Same as test 1, with out_ready toggling 1,0,0,1.
//     -> out_* stable while stalled; no beat is lost or duplicated; done after the 4th beat is accepted.
//  4. During a 1..8 dump, write r2 after it was emitted, and r7 before it is emitted.
//     -> stale=1 at done; beat 7 carries the new value.
//  5. first=last=0, SKIP_R0=1.
//     -> no out_valid; done pulses 1 cycle with stale=0.
//  6. Assert rst mid-dump, after 2 beats.
//     -> all outputs 0 immediately; no done; a later start runs a clean full dump.

Source files
------------

// File: rtl/regs_dump_reader_pkg.sv
// Shared definitions for the register-dump reader slice.
//   ADDR_W_DEF / DATA_W_DEF : default register address/data widths (32 x 32 register file)
//   state_t                 : dump sequencer states
package regs_dump_reader_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/regs_dump_reader_if.sv
// Beat stream from the register-dump reader to the debug/trace unit.
//   out_valid : beat present on out_data/out_addr/out_last
//   out_ready : consumer accepts the beat when out_valid & out_ready
//   out_data  : register value
//   out_addr  : register address of the beat
//   out_last  : final beat of the dump
// master = dump reader side, slave = consumer side.
interface regs_dump_reader_if
  import regs_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regs_dump_reader_outreg.sv
// regs_dump_outreg: one-entry valid/ready output register for the dump stream.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture load_data/load_addr/load_last into the register this edge
//               (caller only asserts it when the slot is empty or being drained)
//   load_*    : beat contents to capture
//   o         : beat stream towards the consumer
module regs_dump_outreg
  import regs_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_last,
  regs_dump_reader_if.master o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      addr_q  <= load_addr;
      last_q  <= load_last;
    end else if (valid_q && o.out_ready) begin
      // Drop last with the accepted beat so out_last never shows without a beat.
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign o.out_valid = valid_q;
  assign o.out_data  = data_q;
  assign o.out_addr  = addr_q;
  assign o.out_last  = last_q;

endmodule

// File: rtl/regs_dump_reader.sv
// regs_dump_reader: walks a register address range through the register file read
// port and streams each value out, flagging the dump stale if a dumped register is
// overwritten before the dump completes.
//   clk, rst              : core clock, asynchronous active-high reset
//   start                 : 1-cycle dump request, ignored while busy
//   first_addr, last_addr : inclusive range (wraps 31->0), sampled on accepted start
//   rf_addr / rf_rdata    : register file read port (combinational read data)
//   wt_addr / wt_en       : register file write port, monitored only
//   busy                  : dump in progress, accepted start through the done cycle
//   done                  : 1-cycle pulse after the final beat is accepted
//   stale                 : qualified by done; a dumped register was written mid-dump
//   dump                  : beat stream (out_valid/out_ready/out_data/out_addr/out_last)
module regs_dump_reader
  import regs_dump_reader_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter bit          SKIP_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic [ADDR_W-1:0] wt_addr,
  input  logic              wt_en,
  output logic              busy,
  output logic              done,
  output logic              stale,
  regs_dump_reader_if.master dump
);

  localparam int unsigned NREG = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;     // one extra bit: a full wrap needs 2**ADDR_W steps
  logic [NREG-1:0]   mask_q;    // registers already captured in this dump
  logic              stale_q;

  logic              start_ok;
  logic              slot_free;
  logic              skip;
  logic              step;
  logic              cap;
  logic              wr_hit;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W:0]   cnt_init;
  logic [DATA_W-1:0] cap_data;
  logic              cap_last;

  always_comb begin
    start_ok  = (state_q == IDLE) && start;
    slot_free = !dump.out_valid || dump.out_ready;
    skip      = SKIP_R0 && (addr_q == '0);
    step      = (state_q == RUN) && (skip || slot_free);
    cap       = (state_q == RUN) && !skip && slot_free;
    span      = last_addr - first_addr;
    cnt_init  = {1'b0, span} + (ADDR_W+1)'(1);
    cap_data  = (addr_q == '0) ? '0 : rf_rdata;
    cap_last  = (cnt_q == (ADDR_W+1)'(1));
    // A write hitting the register captured at this very edge also counts: the
    // register file commits on negedge, after the capture.
    wr_hit    = ((state_q == RUN) || (state_q == DRAIN)) && wt_en && (wt_addr != '0)
                && (mask_q[wt_addr] || (cap && (wt_addr == addr_q)));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (step && cap_last) state_d = DRAIN;
      DRAIN:   if (slot_free) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q  <= first_addr;
        cnt_q   <= cnt_init;
        mask_q  <= '0;
        stale_q <= 1'b0;
      end else begin
        if (step) begin
          addr_q <= addr_q + ADDR_W'(1);
          cnt_q  <= cnt_q - (ADDR_W+1)'(1);
        end
        if (cap) mask_q[addr_q] <= 1'b1;
        if (wr_hit) stale_q <= 1'b1;
      end
    end
  end

  assign rf_addr = (state_q == RUN) ? addr_q : '0;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == FIN);
  assign stale   = done && stale_q;

  regs_dump_outreg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (cap),
    .load_data (cap_data),
    .load_addr (addr_q),
    .load_last (cap_last),
    .o         (dump)
  );

endmodule
